// File: rtl/chirp_ref_sequencer.sv
// Chirp reference sequencer: walks the chirp ROM address space 0..ORDER once per start,
// aligning ROM read latency with a ready/valid handshake. Optional SEQ_CONTINUOUS_EN adds `cont`.
module chirp_ref_sequencer #(
  parameter int unsigned ORDER  = 60,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
`ifdef SEQ_CONTINUOUS_EN
  input  logic              cont,
`endif
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              ref_valid,
  output logic [IDX_W-1:0]  ref_index,
  output logic              ref_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ORDER);

  state_t           r_state;
  logic [IDX_W-1:0] r_index;
  logic             r_done;

  logic             w_cont;
  logic             w_run;
  logic             w_xfer;
  logic             w_at_end;
  logic [IDX_W-1:0] w_addr;

`ifdef SEQ_CONTINUOUS_EN
  assign w_cont = cont;
`else
  assign w_cont = 1'b0;
`endif

  assign w_run    = (r_state == S_RUN);
  assign w_xfer   = w_run && ready;
  assign w_at_end = (r_index == LAST_IDX);

  // Address leads the index by one on a transfer so the ROM's one-cycle latency
  // lands the next sample exactly when ref_index advances; a stall re-reads the current one.
  always_comb begin
    w_addr = '0;
    if (w_run) begin
      if (!ready)
        w_addr = r_index;
      else if (!w_at_end)
        w_addr = r_index + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_index <= '0;
          if (start)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_index <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_at_end) begin
              r_index <= '0;
              r_done  <= 1'b1;
              if (!w_cont)
                r_state <= S_IDLE;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  assign rom_en    = (r_state != S_IDLE);
  assign rom_addr  = ADDR_W'(w_addr);
  assign ref_valid = w_run;
  assign ref_index = r_index;
  assign ref_last  = w_run && w_at_end;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
